pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 34 +++
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   Upstream and downstream contents of one pipeline stage register.
//   in_*  : upstream slot (valid, instr, pc, payload, tnew, jump marker)
//   out_* : registered downstream slot presented to the next stage
//   master : drives in_*, observes out_* (upstream stage / bench)
//   slave  : consumes in_*, drives out_* (the stage register itself)
interface pipe_stage_reg_if #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned TNEW_W    = 2
);
  logic                 in_valid;
  logic [31:0]          in_instr;
  logic [31:0]          in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [TNEW_W-1:0]    in_tnew;
  logic                 in_jump;

  logic                 out_valid;
  logic [31:0]          out_instr;
  logic [31:0]          out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [TNEW_W-1:0]    out_tnew;
  logic                 out_jump;

  modport master (
    output in_valid, in_instr, in_pc, in_payload, in_tnew, in_jump,
    input  out_valid, out_instr, out_pc, out_payload, out_tnew, out_jump
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_payload, in_tnew, in_jump,
    output out_valid, out_instr, out_pc, out_payload, out_tnew, out_jump
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline stage register with exception bubble, flush, stall and tnew
//   countdown, plus a saturating count of inserted bubbles.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset, empties the stage
//   req        : exception/interrupt, insert bubble with pc = EXC_PC
//   flush      : insert bubble keeping in_pc
//   stall      : hold contents (tnew may still count down, see HOLD_DECAY)
//   bus        : in_* upstream slot, out_* registered downstream slot
//   bubble_cnt : saturating number of bubbles inserted
//   Priority per edge: req > flush > stall > load.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W  = 128,
  parameter int unsigned TNEW_W     = 2,
  parameter logic [31:0] EXC_PC     = 32'h0000_4180,
  parameter bit          HOLD_DECAY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               flush,
  input  logic               stall,
  pipe_stage_reg_if.slave    bus,
  output logic [15:0]        bubble_cnt
);

  typedef enum logic [1:0] {
    P_EXC,
    P_BUBBLE,
    P_HOLD,
    P_LOAD
  } path_e;

  path_e                w_path;
  logic [TNEW_W-1:0]    w_in_tnew_dec;
  logic [TNEW_W-1:0]    w_hold_tnew_dec;

  logic                 r_valid;
  logic [31:0]          r_instr;
  logic [31:0]          r_pc;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [TNEW_W-1:0]    r_tnew;
  logic                 r_jump;
  logic [15:0]          r_bubble_cnt;

  // An invalid upstream slot on the load path is treated as a flush.
  always_comb begin
    w_path = P_LOAD;
    if (req)                    w_path = P_EXC;
    else if (flush)             w_path = P_BUBBLE;
    else if (stall)             w_path = P_HOLD;
    else if (!bus.in_valid)     w_path = P_BUBBLE;
  end

  // tnew counts down to zero and never wraps to all-ones.
  always_comb begin
    w_in_tnew_dec   = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TNEW_W'(1);
    w_hold_tnew_dec = (r_tnew == '0)      ? '0 : r_tnew - TNEW_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc         <= '0;
      r_payload    <= '0;
      r_tnew       <= '0;
      r_jump       <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      unique case (w_path)
        P_EXC, P_BUBBLE: begin
          r_valid   <= 1'b0;
          r_instr   <= '0;
          r_pc      <= (w_path == P_EXC) ? EXC_PC : bus.in_pc;
          r_payload <= '0;
          r_tnew    <= '0;
          r_jump    <= 1'b0;
          if (r_bubble_cnt != '1)
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
        P_HOLD: begin
          if (HOLD_DECAY)
            r_tnew <= w_hold_tnew_dec;
        end
        P_LOAD: begin
          r_valid   <= 1'b1;
          r_instr   <= bus.in_instr;
          r_pc      <= bus.in_pc;
          r_payload <= bus.in_payload;
          r_tnew    <= w_in_tnew_dec;
          r_jump    <= bus.in_jump;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_instr   = r_instr;
  assign bus.out_pc      = r_pc;
  assign bus.out_payload = r_payload;
  assign bus.out_tnew    = r_tnew;
  assign bus.out_jump    = r_jump;
  assign bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned PW  = 128;
  localparam int unsigned TW  = 2;
  localparam logic [31:0] EXC = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        req;
  logic        flush;
  logic        stall;
  logic [15:0] bcnt;
  logic [15:0] bcnt2;

  pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) bus  ();
  pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) bus2 ();

  pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(TW), .EXC_PC(EXC), .HOLD_DECAY(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
    .bus(bus.slave), .bubble_cnt(bcnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(TW), .EXC_PC(EXC), .HOLD_DECAY(1'b0)) u_dut_frz (
    .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
    .bus(bus2.slave), .bubble_cnt(bcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [PW-1:0] payload;
    logic [TW-1:0] tnew;
    logic [TW-1:0] tnew2;
    logic          jump;
    logic [15:0]   bcnt;
  } exp_t;

  exp_t q[$];
  exp_t m;  // reference model state of the stage

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  task automatic model_clear();
    m.valid = 0; m.instr = '0; m.pc = '0; m.payload = '0;
    m.tnew = '0; m.tnew2 = '0; m.jump = 0; m.bcnt = '0;
  endtask

  task automatic model_bubble(input logic [31:0] pc);
    m.valid = 0; m.instr = '0; m.pc = pc; m.payload = '0;
    m.tnew = '0; m.tnew2 = '0; m.jump = 0;
    if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
  endtask

  task automatic compare_out(input exp_t e);
    check("valid",   PW'(bus.out_valid),  PW'(e.valid));
    check("instr",   PW'(bus.out_instr),  PW'(e.instr));
    check("pc",      PW'(bus.out_pc),     PW'(e.pc));
    check("payload", bus.out_payload,     e.payload);
    check("tnew",    PW'(bus.out_tnew),   PW'(e.tnew));
    check("jump",    PW'(bus.out_jump),   PW'(e.jump));
    check("bcnt",    PW'(bcnt),           PW'(e.bcnt));
    check("tnew_frozen", PW'(bus2.out_tnew), PW'(e.tnew2));
    check("valid_frozen", PW'(bus2.out_valid), PW'(e.valid));
  endtask

  // Drive one cycle from a negedge; expected result is queued now and
  // popped after the edge. Returns on the following negedge.
  task automatic cyc(input logic rq, input logic fl, input logic st, input logic v,
                     input logic [31:0] instr, input logic [31:0] pc,
                     input logic [PW-1:0] pl, input logic [TW-1:0] tn,
                     input logic jp, input bit do_chk);
    exp_t e;
    req = rq; flush = fl; stall = st;
    bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc;
    bus.in_payload = pl; bus.in_tnew = tn; bus.in_jump = jp;
    bus2.in_valid = v; bus2.in_instr = instr; bus2.in_pc = pc;
    bus2.in_payload = pl; bus2.in_tnew = tn; bus2.in_jump = jp;
    if (reset)          model_clear();
    else if (rq)        model_bubble(EXC);
    else if (fl)        model_bubble(pc);
    else if (st)        m.tnew = dec(m.tnew);
    else if (!v)        model_bubble(pc);
    else begin
      m.valid = 1; m.instr = instr; m.pc = pc; m.payload = pl;
      m.tnew = dec(tn); m.tnew2 = dec(tn); m.jump = jp;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (do_chk) compare_out(e);
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; req = 0; flush = 0; stall = 0;
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.in_payload = '0;
    bus.in_tnew = '0; bus.in_jump = 0;
    bus2.in_valid = 0; bus2.in_instr = '0; bus2.in_pc = '0; bus2.in_payload = '0;
    bus2.in_tnew = '0; bus2.in_jump = 0;
    model_clear();
    #2;
    compare_out(m);
    @(negedge clk);
    reset = 1'b0;

    // Basic load with one-cycle latency
    cyc(0, 0, 0, 1, 32'h2408_0005, 32'h3000, rnd_pl(), 2'd2, 0, 1);

    // Stall decay versus frozen tnew: 1,0,0 vs 2,2,2
    cyc(0, 0, 0, 1, 32'h8C09_0004, 32'h3004, rnd_pl(), 2'd3, 1, 1);
    repeat (3) cyc(0, 0, 1, 1, 32'hDEAD_BEEF, 32'h3FFC, rnd_pl(), 2'd3, 0, 1);

    // req wins over flush and stall; then flush alone keeps in_pc
    cyc(1, 1, 1, 1, 32'h1111_1111, 32'h3010, rnd_pl(), 2'd2, 1, 1);
    cyc(0, 1, 0, 1, 32'h2222_2222, 32'h3010, rnd_pl(), 2'd2, 1, 1);

    // Back-to-back req
    cyc(1, 0, 0, 1, 32'h3333_3333, 32'h3020, rnd_pl(), 2'd1, 0, 1);
    cyc(1, 0, 0, 0, 32'h3333_3333, 32'h3024, rnd_pl(), 2'd1, 0, 1);

    // tnew=0 must not wrap; jump marker captured
    cyc(0, 0, 0, 1, 32'h0000_0008, 32'h3030, rnd_pl(), 2'd0, 1, 1);
    cyc(0, 0, 0, 1, 32'h1000_0003, 32'h3034, rnd_pl(), 2'd1, 0, 1);

    // Invalid load acts as flush; flush beats stall
    cyc(0, 0, 0, 0, 32'h4444_4444, 32'h3038, rnd_pl(), 2'd3, 1, 1);
    cyc(0, 0, 0, 1, 32'h5555_5555, 32'h303C, rnd_pl(), 2'd3, 1, 1);
    cyc(0, 1, 1, 1, 32'h6666_6666, 32'h3040, rnd_pl(), 2'd3, 1, 1);

    // Random mix
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) != 0, $urandom, $urandom, rnd_pl(), TW'($urandom),
          $urandom_range(0, 1) == 1, 1);

    // Asynchronous reset between edges while valid data is held
    cyc(0, 0, 0, 1, 32'h2408_0005, 32'h3100, rnd_pl(), 2'd3, 1, 1);
    cyc(0, 0, 1, 1, 32'h0, 32'h3104, rnd_pl(), 2'd3, 0, 1);
    reset = 1'b1;
    #2;
    model_clear();
    compare_out(m);
    cyc(0, 0, 0, 1, 32'h7777_7777, 32'h3108, rnd_pl(), 2'd2, 1, 1);
    cyc(1, 1, 0, 1, 32'h7777_7777, 32'h310C, rnd_pl(), 2'd2, 1, 1);
    reset = 1'b0;
    // Deasserted mid-stall: stage stays empty
    cyc(0, 0, 1, 1, 32'h8888_8888, 32'h3110, rnd_pl(), 2'd2, 1, 1);

    // Saturation of bubble_cnt
    while (m.bcnt < 16'hFFFE)
      cyc(0, 1, 0, 0, 32'h0, 32'h3200, '0, 2'd0, 0, 0);
    check("bcnt_preload", PW'(bcnt), PW'(16'hFFFE));
    repeat (3) cyc(0, 1, 0, 1, 32'h9999_9999, 32'h3204, rnd_pl(), 2'd1, 0, 1);
    cyc(0, 0, 1, 1, 32'h9999_9999, 32'h3208, rnd_pl(), 2'd1, 0, 1);
    cyc(0, 0, 0, 1, 32'hAAAA_AAAA, 32'h320C, rnd_pl(), 2'd1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
